mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS CPU. It replaces single-cycle combinational control with a state machine that splits each instruction into FETCH, DECODE, EXEC, MEM and WB steps. It drives the shared PC/IR/register-file/ALU/memory datapath one step per cycle and optionally stalls on a memory ready handshake. It sits beside the datapath top, takes `Op`/`Funct` from the registered IR and `Zero` from the ALU, and emits all datapath strobes and selects.

## Interface
- No parameters; encodings come from the shared package.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `Op`  in  6  opcode from IR; valid from DECODE onward
- `Funct`  in  6  funct from IR; valid from DECODE onward
- `Zero`  in  1  ALU zero flag, sampled in EXEC
- `MemReady`  in  1  memory access complete; used only with `MC_CTRL_MEM_HS_EN`
- `PCWrite`  out  1  load PC from NPC
- `IRWrite`  out  1  load IR from instruction memory
- `MemRead`  out  1  memory read request (imem in FETCH, dmem in MEM)
- `MemWrite`  out  1  dmem write strobe
- `RegWrite`  out  1  register file write strobe
- `EXTOp`  out  1  1 = sign-extend immediate
- `ALUSrc`  out  1  ALU B operand: 1 = immediate
- `AREGSel`  out  1  ALU A operand: 1 = shamt
- `ALUOp`  out  4  ALU operation
- `NPCOp`  out  2  00 PC+4, 01 branch, 10 jump, 11 jr
- `GPRSel`  out  2  write register: 00 rd, 01 rt, 10 $31
- `WDSel`  out  2  write data: 00 ALU, 01 MEM, 10 PC
- `State`  out  3  current state, for debug
- `Illegal`  out  1  one-cycle pulse on an unrecognised instruction in DECODE

## Operation
- Supported instructions: add, addu, sub, subu, and, or, nor, slt, sltu, sll, srl, sllv, srlv, jr, jalr, addi, andi, ori, slti, lui, lw, sw, beq, bne, j, jal.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH
  - Asserts `MemRead`.
  - On completion asserts `IRWrite` and `PCWrite` with `NPCOp`=00, then goes to DECODE.
- DECODE
  - j: `PCWrite`, `NPCOp`=10.
  - jal: same as j, plus `RegWrite`, `GPRSel`=10, `WDSel`=10. The written PC is the already-incremented PC+4.
  - jr: `PCWrite`, `NPCOp`=11.
  - jalr: jr signals, plus `RegWrite`, `GPRSel`=00, `WDSel`=10.
  - All four then go to FETCH.
  - Illegal instruction: pulse `Illegal`, no write strobes, go to FETCH.
  - Otherwise go to EXEC.
- EXEC drives `ALUOp`, `ALUSrc`, `AREGSel` and `EXTOp` per instruction.
  - beq/bne: `ALUOp`=SUB; `PCWrite` with `NPCOp`=01 iff `Zero` (beq) or `~Zero` (bne); go to FETCH.
  - lw/sw: go to MEM.
  - All others: go to WB.
- MEM
  - lw: `MemRead`; on completion go to WB.
  - sw: `MemWrite`; on completion go to FETCH.
- WB: `RegWrite` for one cycle, then go to FETCH.
  - R-type: `GPRSel`=00, `WDSel`=00.
  - I-type ALU: `GPRSel`=01, `WDSel`=00.
  - lw: `GPRSel`=01, `WDSel`=01.
- ALU operand and op selects hold their EXEC values through MEM and WB, so the ALU result stays stable.
- `EXTOp`=1 for addi, slti, lw, sw; 0 for andi, ori, lui.
- All write strobes (`PCWrite`, `IRWrite`, `MemWrite`, `RegWrite`) are 0 in any state not listed above.

## Timing
- Reset
  - While `rst`=1: state is forced to FETCH and every output is 0, including `MemRead` and `State`.
  - The first FETCH cycle with outputs active is the cycle after `rst` falls.
- Reset mid-instruction: the instruction is abandoned, no strobe fires in the reset cycle, and there is no partial write-back.
- Latency without stalls:
  - j/jal/jr/jalr: 2 cycles.
  - beq/bne: 3 cycles.
  - R-type and I-type ALU: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Outputs are combinational from the state register and the decoded `Op`/`Funct`. `State` is registered.
- With the handshake, FETCH or MEM holds while `MemReady`=0. During the hold:
  - `MemRead`/`MemWrite` stay asserted.
  - `IRWrite`, `PCWrite` and the state change occur only in the cycle where `MemReady`=1.
- `MemReady` is ignored outside FETCH and MEM.

## Configuration
- `MC_CTRL_MEM_HS_EN` defined: FETCH and MEM wait on `MemReady` as described above.
- Not defined: every memory access completes in one cycle and `MemReady` is unconnected internally.

## Structure
- The shared package (extending the existing encode-def constants) holds:
  - State encoding.
  - ALU codes: NOP 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, LUI 1001, NOR 1010.
  - NPC, GPR and WD select codes.
- Sub-module `mc_decode` is purely combinational. From `Op`/`Funct` it produces:
  - Instruction class: R-ALU, I-ALU, load, store, branch, jump, jr, illegal.
  - `ALUOp`, `ALUSrc`, `AREGSel`, `EXTOp`.
- `mc_ctrl` owns the FSM and strobe gating.

## Test plan
- addu (Op=0, Funct=0x21) → `State` goes 0,1,2,4,0; `RegWrite`=1 only in WB with `GPRSel`=00; `ALUOp`=0001 in EXEC.
- lw (Op=0x23) with `MemReady` held 0 for 3 cycles in MEM, handshake enabled → MEM lasts 4 cycles; `WDSel`=01 and `GPRSel`=01 in WB; total 8 cycles.
- beq (Op=0x04) run once with `Zero`=1 and once with `Zero`=0 → `PCWrite`=1 with `NPCOp`=01 in EXEC only when `Zero`=1; 3 cycles each.
- jal (Op=0x03) → in DECODE, `PCWrite`, `RegWrite`, `GPRSel`=10, `WDSel`=10, `NPCOp`=10; back to FETCH after 2 cycles.
- Op=0x3F → `Illegal` pulses in DECODE; no write strobe; FETCH next.
- `rst` asserted during WB of sll → `RegWrite`=0 in that cycle; FETCH with `MemRead`=1 the cycle after `rst` falls.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, instruction
// classes, ALU codes, next-PC / write-register / write-data selects and opcodes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_RALU,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_JR,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1010;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [1:0] GPR_RD = 2'b00;
  localparam logic [1:0] GPR_RT = 2'b01;
  localparam logic [1:0] GPR_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: classifies Op/Funct and produces the ALU
// operation, operand selects and immediate extension mode.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   i_op,
  input  logic [5:0]   i_funct,
  output instr_class_t o_class,
  output logic         o_link,
  output logic         o_bne,
  output logic [3:0]   o_aluOp,
  output logic         o_aluSrc,
  output logic         o_aregSel,
  output logic         o_extOp
);

  always_comb begin
    o_class   = CLS_ILLEGAL;
    o_link    = 1'b0;
    o_bne     = 1'b0;
    o_aluOp   = ALU_NOP;
    o_aluSrc  = 1'b0;
    o_aregSel = 1'b0;
    o_extOp   = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_class = CLS_RALU;
        case (i_funct)
          FN_ADD, FN_ADDU: o_aluOp = ALU_ADD;
          FN_SUB, FN_SUBU: o_aluOp = ALU_SUB;
          FN_AND:          o_aluOp = ALU_AND;
          FN_OR:           o_aluOp = ALU_OR;
          FN_NOR:          o_aluOp = ALU_NOR;
          FN_SLT:          o_aluOp = ALU_SLT;
          FN_SLTU:         o_aluOp = ALU_SLTU;
          // Constant shifts take the A operand from shamt instead of rs.
          FN_SLL:  begin o_aluOp = ALU_SLL; o_aregSel = 1'b1; end
          FN_SRL:  begin o_aluOp = ALU_SRL; o_aregSel = 1'b1; end
          FN_SLLV:         o_aluOp = ALU_SLL;
          FN_SRLV:         o_aluOp = ALU_SRL;
          FN_JR:           o_class = CLS_JR;
          FN_JALR: begin o_class = CLS_JR; o_link = 1'b1; end
          default:         o_class = CLS_ILLEGAL;
        endcase
      end
      OP_J:    o_class = CLS_JUMP;
      OP_JAL:  begin o_class = CLS_JUMP; o_link = 1'b1; end
      OP_BEQ:  begin o_class = CLS_BRANCH; o_aluOp = ALU_SUB; end
      OP_BNE:  begin o_class = CLS_BRANCH; o_aluOp = ALU_SUB; o_bne = 1'b1; end
      OP_ADDI: begin o_class = CLS_IALU; o_aluOp = ALU_ADD;  o_aluSrc = 1'b1; o_extOp = 1'b1; end
      OP_SLTI: begin o_class = CLS_IALU; o_aluOp = ALU_SLT;  o_aluSrc = 1'b1; o_extOp = 1'b1; end
      OP_ANDI: begin o_class = CLS_IALU; o_aluOp = ALU_AND;  o_aluSrc = 1'b1; end
      OP_ORI:  begin o_class = CLS_IALU; o_aluOp = ALU_OR;   o_aluSrc = 1'b1; end
      OP_LUI:  begin o_class = CLS_IALU; o_aluOp = ALU_LUI;  o_aluSrc = 1'b1; end
      OP_LW:   begin o_class = CLS_LOAD;  o_aluOp = ALU_ADD; o_aluSrc = 1'b1; o_extOp = 1'b1; end
      OP_SW:   begin o_class = CLS_STORE; o_aluOp = ALU_ADD; o_aluSrc = 1'b1; o_extOp = 1'b1; end
      default: o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB). Define MC_CTRL_MEM_HS_EN
// to make FETCH and MEM wait on MemReady; otherwise every memory access takes one cycle.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       EXTOp,
  output logic       ALUSrc,
  output logic       AREGSel,
  output logic [3:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [2:0] State,
  output logic       Illegal
);

  state_t       r_state;
  state_t       w_next;
  instr_class_t w_class;
  logic         w_link;
  logic         w_bne;
  logic [3:0]   w_aluOp;
  logic         w_aluSrc;
  logic         w_aregSel;
  logic         w_extOp;
  logic         w_memDone;

`ifdef MC_CTRL_MEM_HS_EN
  assign w_memDone = MemReady;
`else
  logic w_unusedMemReady;
  assign w_unusedMemReady = MemReady;
  assign w_memDone        = 1'b1;
`endif

  mc_decode u_decode (
    .i_op      (Op),
    .i_funct   (Funct),
    .o_class   (w_class),
    .o_link    (w_link),
    .o_bne     (w_bne),
    .o_aluOp   (w_aluOp),
    .o_aluSrc  (w_aluSrc),
    .o_aregSel (w_aregSel),
    .o_extOp   (w_extOp)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    AREGSel  = 1'b0;
    ALUOp    = ALU_NOP;
    NPCOp    = NPC_PC4;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    Illegal  = 1'b0;
    // ALU selects stay at their EXEC values through MEM and WB so the result is stable.
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      ALUOp   = w_aluOp;
      ALUSrc  = w_aluSrc;
      AREGSel = w_aregSel;
      EXTOp   = w_extOp;
    end
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        if (w_memDone) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = S_FETCH;
        case (w_class)
          CLS_JUMP: begin
            PCWrite = 1'b1;
            NPCOp   = NPC_JUMP;
            if (w_link) begin
              RegWrite = 1'b1;
              GPRSel   = GPR_RA;
              WDSel    = WD_PC;
            end
          end
          CLS_JR: begin
            PCWrite = 1'b1;
            NPCOp   = NPC_JR;
            if (w_link) begin
              RegWrite = 1'b1;
              GPRSel   = GPR_RD;
              WDSel    = WD_PC;
            end
          end
          CLS_ILLEGAL: Illegal = 1'b1;
          default:     w_next  = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (w_class)
          CLS_BRANCH: begin
            w_next = S_FETCH;
            if (w_bne ? ~Zero : Zero) begin
              PCWrite = 1'b1;
              NPCOp   = NPC_BRANCH;
            end
          end
          CLS_LOAD, CLS_STORE: w_next = S_MEM;
          default:             w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (w_class == CLS_LOAD) begin
          MemRead = 1'b1;
          if (w_memDone) w_next = S_WB;
        end else begin
          MemWrite = 1'b1;
          if (w_memDone) w_next = S_FETCH;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
        case (w_class)
          CLS_LOAD: begin GPRSel = GPR_RT; WDSel = WD_MEM; end
          CLS_IALU: begin GPRSel = GPR_RT; WDSel = WD_ALU; end
          default:  begin GPRSel = GPR_RD; WDSel = WD_ALU; end
        endcase
      end
      default: w_next = S_FETCH;
    endcase
    // Reset silences every output in the cycle it is asserted, abandoning any instruction.
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      EXTOp    = 1'b0;
      ALUSrc   = 1'b0;
      AREGSel  = 1'b0;
      ALUOp    = ALU_NOP;
      NPCOp    = NPC_PC4;
      GPRSel   = GPR_RD;
      WDSel    = WD_ALU;
      Illegal  = 1'b0;
    end
  end

  assign State = rst ? 3'd0 : r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: per-cycle output vectors with hand-computed expectations.
// Honours MC_CTRL_MEM_HS_EN for the lw stall expectation.
module tb_mc_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
  logic       EXTOp, ALUSrc, AREGSel, Illegal;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp, GPRSel, WDSel;
  logic [2:0] State;

  int nChecks = 0;
  int nFails  = 0;

  logic [21:0] fetchV;
  logic [21:0] zeroV;

  mc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .Op       (Op),
    .Funct    (Funct),
    .Zero     (Zero),
    .MemReady (MemReady),
    .PCWrite  (PCWrite),
    .IRWrite  (IRWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .RegWrite (RegWrite),
    .EXTOp    (EXTOp),
    .ALUSrc   (ALUSrc),
    .AREGSel  (AREGSel),
    .ALUOp    (ALUOp),
    .NPCOp    (NPCOp),
    .GPRSel   (GPRSel),
    .WDSel    (WDSel),
    .State    (State),
    .Illegal  (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layout: State, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, NPCOp, GPRSel, WDSel,
  // ALUOp, ALUSrc, AREGSel, EXTOp, Illegal.
  function automatic logic [21:0] ev(input int st, input int pcw, input int irw, input int mr,
                                     input int mw, input int rw, input int npc, input int gpr,
                                     input int wd, input int alu, input int src, input int areg,
                                     input int ext, input int ill);
    logic [2:0] s;
    logic [1:0] n, g, w;
    logic [3:0] a;
    s = st[2:0];
    n = npc[1:0];
    g = gpr[1:0];
    w = wd[1:0];
    a = alu[3:0];
    return {s, pcw[0], irw[0], mr[0], mw[0], rw[0], n, g, w, a, src[0], areg[0], ext[0], ill[0]};
  endfunction

  function automatic logic [21:0] obsVec();
    return {State, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, NPCOp, GPRSel, WDSel,
            ALUOp, ALUSrc, AREGSel, EXTOp, Illegal};
  endfunction

  task automatic checkOutput(input string tag, input logic [21:0] actual, input logic [21:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %06h expected %06h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic rdy);
    rst      = r;
    Op       = op;
    Funct    = fn;
    Zero     = z;
    MemReady = rdy;
  endtask

  // Called at posedge+1 with inputs already applied; checks, then advances one cycle.
  task automatic cyc(input string tag, input logic [21:0] expected);
    #1;
    checkOutput(tag, obsVec(), expected);
    @(posedge clk);
    #1;
  endtask

  initial begin
    fetchV = ev(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    zeroV  = '0;

    applyStimulus(1'b1, 6'h00, 6'h21, 1'b0, 1'b1);
    cyc("reset_a", zeroV);
    cyc("reset_b", zeroV);

    // addu: 0,1,2,4 then FETCH
    applyStimulus(1'b0, 6'h00, 6'h21, 1'b0, 1'b1);
    cyc("addu_F", fetchV);
    cyc("addu_D", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("addu_E", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    cyc("addu_W", ev(4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));

    // lw: MemReady low from DECODE; ignored outside FETCH/MEM
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b1);
    cyc("lw_F", fetchV);
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
    cyc("lw_D", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw_E", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
`ifdef MC_CTRL_MEM_HS_EN
    cyc("lw_M_wait1", ev(3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    cyc("lw_M_wait2", ev(3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    cyc("lw_M_wait3", ev(3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b1);
`endif
    cyc("lw_M", ev(3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    applyStimulus(1'b0, 6'h23, 6'h00, 1'b0, 1'b1);
    cyc("lw_W", ev(4, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 1, 0));

    // sw
    applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1);
    cyc("sw_F", fetchV);
    cyc("sw_D", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw_E", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    cyc("sw_M", ev(3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0));

    // beq taken then not taken
    applyStimulus(1'b0, 6'h04, 6'h00, 1'b1, 1'b1);
    cyc("beqT_F", fetchV);
    cyc("beqT_D", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("beqT_E", ev(2, 1, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0));
    applyStimulus(1'b0, 6'h04, 6'h00, 1'b0, 1'b1);
    cyc("beqN_F", fetchV);
    cyc("beqN_D", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("beqN_E", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));

    // bne with Zero=0 is taken
    applyStimulus(1'b0, 6'h05, 6'h00, 1'b0, 1'b1);
    cyc("bne_F", fetchV);
    cyc("bne_D", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("bne_E", ev(2, 1, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0));

    // jal and jalr
    applyStimulus(1'b0, 6'h03, 6'h00, 1'b0, 1'b1);
    cyc("jal_F", fetchV);
    cyc("jal_D", ev(1, 1, 0, 0, 0, 1, 2, 2, 2, 0, 0, 0, 0, 0));
    applyStimulus(1'b0, 6'h00, 6'h09, 1'b0, 1'b1);
    cyc("jalr_F", fetchV);
    cyc("jalr_D", ev(1, 1, 0, 0, 0, 1, 3, 0, 2, 0, 0, 0, 0, 0));

    // ori: zero-extended immediate, writes rt
    applyStimulus(1'b0, 6'h0D, 6'h00, 1'b0, 1'b1);
    cyc("ori_F", fetchV);
    cyc("ori_D", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("ori_E", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0));
    cyc("ori_W", ev(4, 0, 0, 0, 0, 1, 0, 1, 0, 4, 1, 0, 0, 0));

    // illegal opcode
    applyStimulus(1'b0, 6'h3F, 6'h00, 1'b0, 1'b1);
    cyc("ill_F", fetchV);
    cyc("ill_D", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // sll interrupted by reset in WB
    applyStimulus(1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
    cyc("sll_F", fetchV);
    cyc("sll_D", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sll_E", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0));
    applyStimulus(1'b1, 6'h00, 6'h00, 1'b0, 1'b1);
    cyc("sll_W_rst", zeroV);
    applyStimulus(1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
    cyc("post_rst_F", fetchV);
    cyc("post_rst_D", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
